fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one FIFO write port (wr_en/wdata/full) among NREQ requesters.
- Grants are packet-locked: a granted requester owns the port until its last beat, a burst-length cap, or a request drop.
- Sits directly in front of the write side of the FIFO, in the FIFO write-clock domain.
- Also counts stall cycles caused by FIFO back-pressure.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data width; must match the FIFO data width.
- MAX_BURST, 16, maximum accepted beats per grant (1..256).
- IDW, 2, width of the grant index; must equal clog2(NREQ).

Ports:
- clk_i  input  1  single clock; same clock as the FIFO write clock.
- rst_n_i  input  1  reset, asynchronous, active-low.
- req_i  input  NREQ  per-requester write request; level, held while data is valid.
- last_i  input  NREQ  per-requester last-beat-of-packet flag; qualified by req_i.
- wdata_i  input  NREQ*WIDTH  packed request data; requester k occupies bits [k*WIDTH +: WIDTH].
- full_i  input  1  FIFO full flag.
- ack_o  output  NREQ  one-hot; beat accepted this cycle (combinational).
- wr_en_o  output  1  FIFO write enable (combinational).
- wdata_o  output  WIDTH  FIFO write data: wdata_i slice of the granted requester; 0 when no grant.
- gnt_o  output  NREQ  registered one-hot current owner.
- gnt_id_o  output  IDW  registered index of the current owner.
- busy_o  output  1  high in state BURST.
- stall_cnt_o  output  16  saturating count of stall cycles.

Behaviour:
- Reset (rst_n_i=0, asynchronous):
  - state=IDLE; gnt_o=0; gnt_id_o=0; busy_o=0; stall_cnt_o=0; beat count=0.
  - Round-robin last-winner pointer=NREQ-1, so requester 0 has highest priority first.
  - Combinational outputs are 0 while in reset.
- Reset deassertion is sampled on clk_i.
- A reset mid-burst abandons the packet. No FIFO write occurs while rst_n_i=0.
- State IDLE:
  - wr_en_o=0, ack_o=0.
  - If req_i≠0, the winner is the first set bit searching upward from last_winner+1, with wrap-around modulo NREQ.
  - At the next edge: gnt_o/gnt_id_o load the winner, last_winner=winner, beat count=0, state→BURST.
  - Arbitration latency is 1 cycle (grant visible the cycle after the request is seen in IDLE). No data is accepted during the arbitration cycle.
- State BURST (g=gnt_id_o):
  - wr_en_o = req_i[g] & ~full_i; ack_o[g] = wr_en_o; all other ack_o bits are 0; wdata_o = slice g.
  - Each accepted beat increments beat count.
  - BURST→IDLE (gnt_o cleared at the same edge) on any of:
    - accepted beat with last_i[g]=1;
    - accepted beat that makes beat count equal MAX_BURST;
    - req_i[g]=0 (release, no write that cycle).
  - Otherwise stay in BURST.
  - Requests from non-owners are ignored until the return to IDLE. They are not dropped; they win later by round-robin.
- Full handling:
  - When full_i=1 in BURST with req_i[g]=1: wr_en_o=0, no ack, grant held, stall_cnt_o+1, saturating at 16'hFFFF.
  - The arbiter never asserts wr_en_o while full_i=1, so FIFO overflow errors are impossible from this block.
- Simultaneous events:
  - last_i with full_i=1: the beat is not accepted and the grant is held.
  - Cap reached on a last_i beat: a single exit to IDLE.
- Back-to-back packets always pass through one IDLE cycle, i.e. one dead cycle between grants.
- gnt_o is always one-hot or zero. gnt_id_o holds its value when gnt_o=0.

Test Plan:
- Reset then req_i=4'b0001, 3 beats with last on beat 3, full_i=0 → gnt_o=0001 one cycle after req. Exactly 3 wr_en_o pulses with wdata_o equal to the sent bytes. busy_o drops after beat 3.
- req_i=4'b1111 constant, each packet 2 beats → grant order 0,1,2,3,0. One idle cycle between grants. 8 wr_en_o pulses per full round.
- MAX_BURST=16, requester 2 streams 20 beats with no last while requester 3 requests → grant released after 16 accepted beats. Requester 3 granted next. Requester 2 re-granted afterwards for the remaining 4 beats.
- Requester 1 granted, full_i=1 for 5 cycles mid-packet → wr_en_o=0 and ack_o=0 for those 5 cycles, stall_cnt_o increases by 5, grant kept, data resumes unchanged.
- Requester 0 granted, req_i[0] drops after 1 beat with no last → return to IDLE the next edge. Pending requester 2 is granted the cycle after.
- rst_n_i pulsed low asynchronously mid-burst → gnt_o, busy_o and stall_cnt_o go 0 immediately, with no clock edge needed. After release, requester 0 has first priority.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter that shares one FIFO write port among NREQ requesters.
// It also keeps a saturating count of cycles the owner spent blocked by FIFO back-pressure.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16,
  parameter int IDW       = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ-1:0]       last_i,
  input  logic [NREQ*WIDTH-1:0] wdata_i,
  input  logic                  full_i,
  output logic [NREQ-1:0]       ack_o,
  output logic                  wr_en_o,
  output logic [WIDTH-1:0]      wdata_o,
  output logic [NREQ-1:0]       gnt_o,
  output logic [IDW-1:0]        gnt_id_o,
  output logic                  busy_o,
  output logic [15:0]           stall_cnt_o
);

  // Handshake: a beat moves when the owner holds req_i high and full_i is low.
  // ack_o and wr_en_o are asserted combinationally in that same cycle.
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [15:0]     stall_q, stall_d;

  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   idx;
  logic             found;
  logic             owner_req;
  logic             owner_last;
  logic             accept;
  logic             cap_hit;
  logic [WIDTH-1:0] sel_data;

  // Search upward from the previous winner, wrapping modulo NREQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(last_q) + i) % NREQ);
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_id_q == IDW'(k)) sel_data = wdata_i[k*WIDTH +: WIDTH];
    end
  end

  assign owner_req  = req_i[gnt_id_q];
  assign owner_last = last_i[gnt_id_q];
  assign accept     = (state_q == BURST) & owner_req & ~full_i;
  assign cap_hit    = (beat_q + 1'b1) == CW'(MAX_BURST);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    last_d   = last_q;
    beat_d   = beat_q;
    stall_d  = stall_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = BURST;
          gnt_d    = NREQ'(1) << winner;
          gnt_id_d = winner;
          last_d   = winner;
          beat_d   = '0;
        end
      end
      BURST: begin
        if (!owner_req) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (full_i) begin
          stall_d = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
        end else begin
          beat_d = beat_q + 1'b1;
          if (owner_last || cap_hit) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      last_q   <= IDW'(NREQ - 1);
      beat_q   <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      last_q   <= last_d;
      beat_q   <= beat_d;
      stall_q  <= stall_d;
    end
  end

  // Gating with rst_n_i keeps the write port quiet for the whole reset pulse.
  assign wr_en_o     = rst_n_i & accept;
  assign ack_o       = {NREQ{wr_en_o}} & gnt_q;
  assign wdata_o     = (rst_n_i && state_q == BURST) ? sel_data : '0;
  assign gnt_o       = gnt_q;
  assign gnt_id_o    = gnt_id_q;
  assign busy_o      = (state_q == BURST);
  assign stall_cnt_o = stall_q;

endmodule
